ssd_scan_ctrl: RTL
==================

# ssd_scan_ctrl

Time-multiplexed scan controller for a multi-digit seven-segment display. It holds a frame of BCD digit codes, cycles one-hot anode enables across the digits, and feeds a single shared `ssd` decoder instance with the selected digit's code. A blanking gap between digits suppresses ghosting. New display words are accepted through a valid/ready handshake and applied only at a frame boundary, so a frame never mixes old and new digits. It sits between the register/CPU side that produces digit values and the display pins.

## Interface
- `DIGITS`, 4: number of digits scanned; legal 1..8.
- `PRESCALE`, 1000: clock cycles each digit is driven.
- `BLANK_CYC`, 2: clock cycles of dead time before each digit; legal ≥1.

- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  new display word offered.
- `wr_data`  in  4*DIGITS  digit codes; bits [4i+3:4i] belong to digit i.
- `wr_ready`  out  1  shadow buffer empty; word accepted when `wr_valid && wr_ready`.
- `digit_en`  in  DIGITS  per-digit enable; a 0 bit keeps that digit dark.
- `anode`  out  DIGITS  one-hot digit select, active-high; all-zero while blanking.
- `segments`  out  7  abcd_efg pattern from the shared decoder, active-high.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - `active`, the frame in use; reset all `4'hF`.
  - `pending` buffer plus `pend_full` flag; reset 0.
  - Digit index `idx`; reset 0.
  - Phase counter.
  - Registered `seg_code` and `anode`.
- FSM states:
  - BLANK: `anode` = 0, `seg_code` = `4'hF`, so the decoder outputs 0. Lasts `BLANK_CYC` cycles, then goes to DRIVE.
  - DRIVE: `seg_code` = `active[idx]`. `anode` = one-hot(`idx`) if `digit_en[idx]`, else 0. `digit_en` is sampled on entry to DRIVE. Lasts `PRESCALE` cycles, then `idx` increments and the FSM returns to BLANK.
- Wrap-around: when DRIVE ends with `idx` = `DIGITS-1`:
  - `idx` returns to 0 and `frame_done` pulses in the same cycle.
  - If `pend_full`, `active` ← `pending` and `pend_full` clears.
- Handshake:
  - `wr_ready` = !`pend_full`.
  - Acceptance sets `pend_full` and captures `wr_data` into `pending`.
  - Once full, further `wr_valid` is ignored until the frame boundary frees the buffer.
- Simultaneous accept and frame-boundary transfer: these cannot collide, because acceptance requires `pend_full` = 0 and transfer requires `pend_full` = 1.
- Digit codes 10–15 display blank, through the decoder's default case.
- Reset mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - A pending word is discarded.
  - Display blanks: `anode` = 0, `segments` = 0.
- Counter width is `$clog2(max(PRESCALE, BLANK_CYC))`. The counter counts 0..N-1 and clears on every phase change.

## Timing
- Slot length is `BLANK_CYC+PRESCALE` cycles; frame length is `DIGITS` × slot.
- After `reset` deasserts: the first `BLANK_CYC` cycles are BLANK for digit 0, then digit 0 is driven.
- `anode` and `seg_code` are registered together, so `segments` changes in the same cycle as `anode`.
- An accepted word is displayed starting with digit 0 of the next frame. Worst-case latency is one frame plus `BLANK_CYC` cycles.
- `wr_ready` rises the cycle after `frame_done`.
- `frame_done` is registered and asserts in the first BLANK cycle of digit 0.

## Structure
- Shared package `ssd_pkg`:
  - `BLANK_CODE` = `4'hF`.
  - Scan state enum {BLANK, DRIVE}.
  - Default parameter constants.
- Sub-modules:
  - One instance of the existing `ssd` decoder, on `seg_code`.
  - Phase timing may be split into sub-module `ssd_scan_timer`. It takes load/length inputs and produces a `phase_end` output.

## Test plan
Bench parameters: `DIGITS`=4, `PRESCALE`=4, `BLANK_CYC`=2 (slot = 6 cycles, frame = 24 cycles).

- **Reset:** assert `reset` → `anode`=0, `segments`=0, `wr_ready`=1, `frame_done`=0. Release and run one frame with no write → `anode` walks `0001,0010,0100,1000` (4 cycles each, 2 blank cycles between); `segments`=0 throughout.
- **Write `16'h4321`:** accepted in the cycle it is offered. From the next frame boundary, digit 0 shows `7'b0110000`, digit 1 `7'b1101101`, digit 2 `7'b1111001`, digit 3 `7'b0110011`.
- **Back-to-back writes:** offer `16'h1111` then `16'h2222` within one frame → `wr_ready` drops after the first; the second is held until `wr_ready` rises after `frame_done`. The frame after that shows all 1s; the following frame shows all 2s; no frame is mixed.
- **Digit enable:** `digit_en`=`4'b1010` → `anode` is only ever `0010` or `1000`; slot timing is unchanged (24-cycle frame).
- **Reset mid-frame:** assert `reset` during the DRIVE of digit 2 while a word is pending → outputs are blank asynchronously. After release, scanning restarts at digit 0 with `active` all `F`, and `wr_ready`=1.
- **Out-of-range codes:** write `16'hFA98` → digits 0–1 show 8 and 9; digits 2–3 show `segments`=0 while their anodes are active.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the seven-segment scan controller.
//   BLANK_CODE    digit code that the decoder renders as all segments off
//   scan_state_t  scan phase (BLANK dead time / DRIVE digit on)
//   DEF_*         default parameter values for ssd_scan_ctrl
//   cnt_width()   phase counter width for a given drive/blank length pair
package ssd_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int DEF_DIGITS    = 4;
  localparam int DEF_PRESCALE  = 1000;
  localparam int DEF_BLANK_CYC = 2;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Counter counts 0..len-1 for the longer of the two phases; never narrower
  // than one bit so a 1-cycle configuration still has a real register.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/ssd.sv
// ssd: combinational BCD to seven-segment decoder.
//   i_code      4-bit digit code
//   o_segments  {a,b,c,d,e,f,g}, active-high; codes 10..15 give all-off
module ssd (
  input  logic [3:0] i_code,
  output logic [6:0] o_segments
);

  always_comb begin
    o_segments = 7'b0000000;
    case (i_code)
      4'd0:    o_segments = 7'b1111110;
      4'd1:    o_segments = 7'b0110000;
      4'd2:    o_segments = 7'b1101101;
      4'd3:    o_segments = 7'b1111001;
      4'd4:    o_segments = 7'b0110011;
      4'd5:    o_segments = 7'b1011011;
      4'd6:    o_segments = 7'b1011111;
      4'd7:    o_segments = 7'b1110000;
      4'd8:    o_segments = 7'b1111111;
      4'd9:    o_segments = 7'b1111011;
      default: o_segments = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/ssd_scan_timer.sv
// ssd_scan_timer: phase length counter for the scan FSM.
//   clk, reset    clock and asynchronous active-high reset
//   i_load        restart the count at 0 on the next edge
//   i_len         length of the current phase in cycles (>= 1)
//   o_phase_end   high during the last cycle of the current phase
module ssd_scan_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W:0]   i_len,
  output logic             o_phase_end
);

  logic [CNT_W-1:0] r_cnt;

  // i_len carries one extra bit so the full phase length is representable.
  assign o_phase_end = ({1'b0, r_cnt} == (i_len - 1'b1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed scan controller for a multi-digit
// seven-segment display with frame-synchronous word updates.
//   clk, reset   clock and asynchronous active-high reset
//   wr_valid     new display word offered
//   wr_data      digit codes, bits [4i+3:4i] for digit i
//   wr_ready     shadow buffer empty; accepted on wr_valid && wr_ready
//   digit_en     per-digit enable, sampled on entry to DRIVE
//   anode        one-hot digit select, all-zero while blanking
//   segments     decoded pattern {a,b,c,d,e,f,g}
//   frame_done   one-cycle pulse in the first BLANK cycle of digit 0
//
// state | meaning
// ------+-----------------------------------------------------------
// BLANK | dead time before a digit, anode = 0, seg code = BLANK_CODE
// DRIVE | digit idx lit with active[idx] (anode gated by digit_en)
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DIGITS    = DEF_DIGITS,
  parameter int PRESCALE  = DEF_PRESCALE,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [4*DIGITS-1:0]   wr_data,
  output logic                  wr_ready,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            segments,
  output logic                  frame_done
);

  localparam int CNT_W = cnt_width(PRESCALE, BLANK_CYC);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef logic [CNT_W:0] len_t;

  localparam len_t             LEN_BLANK = len_t'(BLANK_CYC);
  localparam len_t             LEN_DRIVE = len_t'(PRESCALE);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

  scan_state_t               r_state;
  scan_state_t               w_state_nxt;
  logic [IDX_W-1:0]          r_idx;
  logic [DIGITS-1:0][3:0]    r_active;
  logic [DIGITS-1:0][3:0]    r_pending;
  logic                      r_pend_full;
  logic                      r_xfer;
  logic                      r_frame_done;
  logic [DIGITS-1:0]         r_anode;
  logic [3:0]                r_seg_code;

  logic [DIGITS-1:0]         w_anode_nxt;
  logic [3:0]                w_seg_nxt;
  logic [DIGITS-1:0]         w_onehot;
  len_t                      w_len;
  logic                      w_phase_end;
  logic                      w_drive_end;
  logic                      w_wrap;
  logic                      w_accept;

  assign w_onehot    = DIGITS'(1) << r_idx;
  assign w_drive_end = (r_state == DRIVE) && w_phase_end;
  assign w_wrap      = w_drive_end && (r_idx == LAST_IDX);
  assign w_accept    = wr_valid && !r_pend_full;

  ssd_scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_phase_end),
    .i_len       (w_len),
    .o_phase_end (w_phase_end)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (w_phase_end) begin
      w_state_nxt = (r_state == BLANK) ? DRIVE : BLANK;
    end
  end

  // FSM: outputs. anode/seg code are computed for the next state and
  // registered together, so segments and anode switch on the same edge.
  always_comb begin
    w_len       = (r_state == BLANK) ? LEN_BLANK : LEN_DRIVE;
    w_anode_nxt = r_anode;
    w_seg_nxt   = r_seg_code;
    if (w_phase_end) begin
      if (r_state == BLANK) begin
        w_anode_nxt = digit_en[r_idx] ? w_onehot : '0;
        w_seg_nxt   = r_active[r_idx];
      end else begin
        w_anode_nxt = '0;
        w_seg_nxt   = BLANK_CODE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_anode    <= '0;
      r_seg_code <= BLANK_CODE;
      r_idx      <= '0;
    end else begin
      r_anode    <= w_anode_nxt;
      r_seg_code <= w_seg_nxt;
      if (w_drive_end) begin
        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Frame buffer. The word moves into active on the wrap edge, but the
  // shadow stays marked full for the frame_done cycle so wr_ready rises
  // the cycle after frame_done. r_xfer remembers that a transfer really
  // happened, so a word accepted in the wrap cycle itself is not dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active     <= '1;
      r_pending    <= '0;
      r_pend_full  <= 1'b0;
      r_xfer       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      r_xfer       <= w_wrap && r_pend_full;
      if (w_wrap && r_pend_full) begin
        r_active <= r_pending;
      end
      if (w_accept) begin
        r_pending   <= wr_data;
        r_pend_full <= 1'b1;
      end else if (r_xfer) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  ssd u_ssd (
    .i_code     (r_seg_code),
    .o_segments (segments)
  );

  assign anode      = r_anode;
  assign wr_ready   = !r_pend_full;
  assign frame_done = r_frame_done;

endmodule
